// File: rtl/cache_pkg.sv
// Shared cache-subsystem types: bus opcodes, widths, arbiter request and state types.
package cache_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;

    typedef logic [ADDR_W-1:0] UbitAddr;
    typedef logic [DATA_W-1:0] UbitData;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } Op;

    typedef struct packed {
        Op       op;
        UbitAddr addr;
        UbitData data;
    } MemReq;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_RD = 1'b1
    } ArbState;

endpackage

// File: rtl/mem_bus.sv
// Single-beat memory bus: one-cycle request, one-cycle response pulse.
interface MemBus;
    import cache_pkg::*;

    Op       req_op;
    UbitAddr req_addr;
    UbitData req_data;
    logic    rsp_vld;
    UbitData rsp_data;

    modport rx_bp (input req_op, req_addr, req_data, output rsp_vld, rsp_data);
    modport tx_bp (output req_op, req_addr, req_data, input rsp_vld, rsp_data);

endinterface

// File: rtl/mem_req_slot.sv
// One-entry request buffer; a fill into an occupied entry is dropped and flagged.
module mem_req_slot
    import cache_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_fill,
    input  MemReq i_req,
    input  logic  i_clr,
    output logic  o_vld,
    output MemReq o_req,
    output logic  o_ovf
);

    logic  r_vld;
    MemReq r_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_req <= '0;
        end else if (i_fill && !r_vld) begin
            r_vld <= 1'b1;
            r_req <= i_req;
        end else if (i_clr) begin
            r_vld <= 1'b0;
        end
    end

    assign o_vld = r_vld;
    assign o_req = r_req;
    assign o_ovf = i_fill && r_vld;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between two requesters; reads block, writes are posted.
module mem_arbiter (
    input  logic   clk,
    input  logic   rst,
    MemBus.rx_bp   rx0,
    MemBus.rx_bp   rx1,
    MemBus.tx_bp   tx,
    output logic   err
);
    import cache_pkg::*;

    ArbState r_state, w_state_nxt;

    logic    w_vld0, w_vld1, w_ovf0, w_ovf1;
    logic    w_clr0, w_clr1;
    MemReq   w_in0, w_in1, w_slot0, w_slot1, w_sel_req;
    logic    w_gnt, w_sel;

    Op       r_tx_op;
    UbitAddr r_tx_addr;
    UbitData r_tx_data;
    logic    [1:0] r_rsp_vld;
    UbitData r_rsp_data0, r_rsp_data1;
    logic    r_rr, r_own, r_err;

    assign w_in0 = '{op: rx0.req_op, addr: rx0.req_addr, data: rx0.req_data};
    assign w_in1 = '{op: rx1.req_op, addr: rx1.req_addr, data: rx1.req_data};

    mem_req_slot u_slot0 (
        .clk    (clk),
        .rst    (rst),
        .i_fill (rx0.req_op != NOP),
        .i_req  (w_in0),
        .i_clr  (w_clr0),
        .o_vld  (w_vld0),
        .o_req  (w_slot0),
        .o_ovf  (w_ovf0)
    );

    mem_req_slot u_slot1 (
        .clk    (clk),
        .rst    (rst),
        .i_fill (rx1.req_op != NOP),
        .i_req  (w_in1),
        .i_clr  (w_clr1),
        .o_vld  (w_vld1),
        .o_req  (w_slot1),
        .o_ovf  (w_ovf1)
    );

    // rr names the preferred port; fall back to the other when its slot is empty
    assign w_sel     = r_rr ? w_vld1 : !w_vld0;
    assign w_gnt     = (r_state == IDLE) && (w_vld0 || w_vld1);
    assign w_sel_req = w_sel ? w_slot1 : w_slot0;
    assign w_clr0    = w_gnt && !w_sel;
    assign w_clr1    = w_gnt && w_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt && w_sel_req.op == READ) w_state_nxt = WAIT_RD;
            WAIT_RD: if (tx.rsp_vld) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_op     <= NOP;
            r_tx_addr   <= '0;
            r_tx_data   <= '0;
            r_rsp_vld   <= '0;
            r_rsp_data0 <= '0;
            r_rsp_data1 <= '0;
            r_rr        <= 1'b0;
            r_own       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_tx_op   <= NOP;
            r_rsp_vld <= '0;
            if (w_gnt) begin
                r_tx_op   <= w_sel_req.op;
                r_tx_addr <= w_sel_req.addr;
                r_tx_data <= w_sel_req.data;
                r_rr      <= !w_sel;
                if (w_sel_req.op == WRITE) begin
                    r_rsp_vld[w_sel] <= 1'b1;
                    if (w_sel) r_rsp_data1 <= '0;
                    else       r_rsp_data0 <= '0;
                end else begin
                    r_own <= w_sel;
                end
            end
            if (r_state == WAIT_RD && tx.rsp_vld) begin
                r_rsp_vld[r_own] <= 1'b1;
                if (r_own) r_rsp_data1 <= tx.rsp_data;
                else       r_rsp_data0 <= tx.rsp_data;
            end
            if (w_ovf0 || w_ovf1 || (r_state == IDLE && tx.rsp_vld)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign tx.req_op   = r_tx_op;
    assign tx.req_addr = r_tx_addr;
    assign tx.req_data = r_tx_data;
    assign rx0.rsp_vld  = r_rsp_vld[0];
    assign rx0.rsp_data = r_rsp_data0;
    assign rx1.rsp_vld  = r_rsp_vld[1];
    assign rx1.rsp_data = r_rsp_data1;
    assign err          = r_err;

endmodule
